// File: rtl/sms_pkg.sv
// Shared save-RAM definitions: sector size and backup controller state encoding.
package sms_pkg;

  localparam int SECT_BYTES = 512;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } sav_state_t;

endpackage

// File: rtl/sav_backup_ctrl.sv
// Save-RAM backup sequencer: loads the backup image on mount, writes it back on request.
// Optional idle-timed autosave after core writes is built with `define SAV_AUTOSAVE_EN.
module sav_backup_ctrl
  import sms_pkg::*;
#(
  parameter int          SECTORS  = 16,
  parameter logic [23:0] IDLE_CYC = 24'd5_000_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [31:0] img_size,
  input  logic        ioctl_download,
  input  logic        save_req,
  input  logic        sd_ack,
  input  logic        nvram_we,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        bk_ena,
  output logic        bk_reset,
  output logic        busy
);

  localparam int LBA_W = (SECTORS > 1) ? $clog2(SECTORS) : 1;
  localparam logic [LBA_W-1:0] LAST_LBA = LBA_W'(SECTORS - 1);

  sav_state_t       state, state_nxt;
  logic [LBA_W-1:0] lba_cnt, lba_nxt;
  logic             rd_nxt, wr_nxt, bk_reset_nxt;
  logic             is_load, is_load_nxt;
  logic             abort, abort_nxt;
  logic             save_start;
  logic             auto_fire;

  // Edge registers track the inputs even in reset, so a level already high at release is not an edge.
  logic mount_q, save_q, dl_q, ack_q;

  always_ff @(posedge clk_sys) begin
    mount_q <= img_mounted;
    save_q  <= save_req;
    dl_q    <= ioctl_download;
    ack_q   <= sd_ack;
  end

  logic mount_rise, save_rise, dl_rise, ack_rise, ack_fall, mount_set;
  assign mount_rise = img_mounted & ~mount_q;
  assign save_rise  = save_req & ~save_q;
  assign dl_rise    = ioctl_download & ~dl_q;
  assign ack_rise   = sd_ack & ~ack_q;
  assign ack_fall   = ~sd_ack & ack_q;
  assign mount_set  = mount_rise & (img_size != 32'd0);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bk_ena <= 1'b0;
    end else if (dl_rise) begin
      bk_ena <= 1'b0;
    end else if (mount_set) begin
      bk_ena <= 1'b1;
    end
  end

`ifdef SAV_AUTOSAVE_EN
  logic        dirty;
  logic [23:0] quiet_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dirty     <= 1'b0;
      quiet_cnt <= 24'd0;
    end else begin
      if (nvram_we) begin
        dirty <= 1'b1;
      end else if (save_start) begin
        dirty <= 1'b0;
      end
      if (nvram_we) begin
        quiet_cnt <= 24'd0;
      end else if (quiet_cnt != IDLE_CYC) begin
        quiet_cnt <= quiet_cnt + 24'd1;
      end
    end
  end

  assign auto_fire = dirty & (quiet_cnt == IDLE_CYC);
`else
  logic unused_autosave;
  assign unused_autosave = ^{nvram_we, IDLE_CYC};
  assign auto_fire       = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      lba_cnt  <= '0;
      sd_rd    <= 1'b0;
      sd_wr    <= 1'b0;
      bk_reset <= 1'b0;
      is_load  <= 1'b0;
      abort    <= 1'b0;
    end else begin
      state    <= state_nxt;
      lba_cnt  <= lba_nxt;
      sd_rd    <= rd_nxt;
      sd_wr    <= wr_nxt;
      bk_reset <= bk_reset_nxt;
      is_load  <= is_load_nxt;
      abort    <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lba_nxt      = lba_cnt;
    rd_nxt       = sd_rd;
    wr_nxt       = sd_wr;
    bk_reset_nxt = 1'b0;
    is_load_nxt  = is_load;
    abort_nxt    = abort;
    save_start   = 1'b0;

    case (state)
      IDLE: begin
        abort_nxt = 1'b0;
        // A mount sets bk_ena this same cycle, so it may start a load directly; a download edge vetoes both.
        if (mount_set && !dl_rise) begin
          state_nxt   = REQ;
          lba_nxt     = '0;
          rd_nxt      = 1'b1;
          wr_nxt      = 1'b0;
          is_load_nxt = 1'b1;
        end else if ((save_rise || auto_fire) && bk_ena && !dl_rise) begin
          state_nxt   = REQ;
          lba_nxt     = '0;
          rd_nxt      = 1'b0;
          wr_nxt      = 1'b1;
          is_load_nxt = 1'b0;
          save_start  = 1'b1;
        end
      end

      REQ: begin
        // An unusually fast host may ack here; catch it so the edge is not lost.
        if (ack_rise) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          state_nxt = WAIT_DONE;
        end else begin
          state_nxt = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (ack_rise) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          state_nxt = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (ack_fall) begin
          if (lba_cnt == LAST_LBA || abort || dl_rise) begin
            state_nxt    = IDLE;
            bk_reset_nxt = is_load & ~abort & ~dl_rise;
          end else begin
            lba_nxt   = lba_cnt + LBA_W'(1);
            rd_nxt    = is_load;
            wr_nxt    = ~is_load;
            state_nxt = WAIT_ACK;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (state != IDLE && dl_rise) begin
      abort_nxt = 1'b1;
    end
  end

  assign sd_lba = {{(32 - LBA_W){1'b0}}, lba_cnt};
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_sav_backup_ctrl.sv
// Directed bench for sav_backup_ctrl: vector table plus multi-sector load/save/abort/reset sequences.
module tb_sav_backup_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset, img_mounted, ioctl_download, save_req, nvram_we;
  logic [31:0] img_size;
  logic        tbl_ack, resp_ack, ack_en;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, bk_ena, bk_reset, busy;

  always #5 clk_sys = ~clk_sys;

  assign sd_ack = ack_en ? resp_ack : tbl_ack;

  sav_backup_ctrl #(.SECTORS(16), .IDLE_CYC(24'd100)) dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
    .ioctl_download(ioctl_download), .save_req(save_req), .sd_ack(sd_ack), .nvram_we(nvram_we),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .bk_ena(bk_ena), .bk_reset(bk_reset), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Request/pulse monitor, sampled 1 time unit after each edge.
  int          rd_cnt = 0, wr_cnt = 0, bkr_cnt = 0, bkr_long = 0;
  logic [31:0] rd_lbas[$];
  logic [31:0] wr_lbas[$];
  initial begin
    logic prd, pwr, pbk;
    prd = 1'b0; pwr = 1'b0; pbk = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (sd_rd && !prd) begin rd_cnt++; rd_lbas.push_back(sd_lba); end
      if (sd_wr && !pwr) begin wr_cnt++; wr_lbas.push_back(sd_lba); end
      if (bk_reset && !pbk) bkr_cnt++;
      if (bk_reset && pbk) bkr_long++;
      prd = sd_rd; pwr = sd_wr; pbk = bk_reset;
    end
  end

  // Host model: ack 3 cycles after a request, hold 2 cycles.
  initial begin
    resp_ack = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (ack_en && (sd_rd || sd_wr) && !resp_ack) begin
        repeat (3) @(posedge clk_sys);
        #1 resp_ack = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1 resp_ack = 1'b0;
      end
    end
  end

  typedef struct {
    logic        rst, mnt;
    logic [31:0] sz;
    logic        dl, sv, ack;
    logic        e_rd, e_wr, e_ena, e_bkr, e_bsy;
    logic [31:0] e_lba;
  } vec_t;

  function automatic vec_t v(input logic rst, mnt, input logic [31:0] sz, input logic dl, sv, ack,
                             input logic rd, wr, ena, bkr, bsy, input logic [31:0] lba);
    vec_t r;
    r.rst = rst; r.mnt = mnt; r.sz = sz; r.dl = dl; r.sv = sv; r.ack = ack;
    r.e_rd = rd; r.e_wr = wr; r.e_ena = ena; r.e_bkr = bkr; r.e_bsy = bsy; r.e_lba = lba;
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1; img_mounted = 1'b0; ioctl_download = 1'b0; save_req = 1'b0; nvram_we = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin step(1); n++; end
    chk(name, 32'(n < limit), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[22];
    int   b_rd, b_wr, b_bk, b_qr, b_qw, bad, n;

    reset = 1'b1; img_mounted = 1'b0; img_size = 32'd0; ioctl_download = 1'b0;
    save_req = 1'b0; nvram_we = 1'b0; tbl_ack = 1'b0; ack_en = 1'b0;

    //             rst mnt  sz   dl sv ack    rd wr ena bkr bsy lba
    tbl[0]  = v(1, 0, 0,    0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[1]  = v(1, 1, 8192, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[2]  = v(0, 1, 8192, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // level high at release: no edge
    tbl[3]  = v(0, 0, 8192, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[4]  = v(0, 0, 8192, 0, 1, 0,   0, 0, 0, 0, 0, 0);  // save without backup ignored
    tbl[5]  = v(0, 1, 0,    0, 0, 0,   0, 0, 0, 0, 0, 0);  // zero-size mount
    tbl[6]  = v(0, 0, 0,    0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[7]  = v(0, 1, 8192, 0, 0, 0,   1, 0, 1, 0, 1, 0);  // load starts
    tbl[8]  = v(0, 1, 8192, 0, 0, 0,   1, 0, 1, 0, 1, 0);
    tbl[9]  = v(0, 1, 8192, 0, 0, 1,   0, 0, 1, 0, 1, 0);
    tbl[10] = v(0, 0, 8192, 0, 1, 1,   0, 0, 1, 0, 1, 0);  // save edge while busy ignored
    tbl[11] = v(0, 0, 8192, 0, 0, 0,   1, 0, 1, 0, 1, 1);
    tbl[12] = v(0, 0, 8192, 1, 0, 0,   1, 0, 0, 0, 1, 1);  // download mid-transfer
    tbl[13] = v(0, 0, 8192, 1, 0, 1,   0, 0, 0, 0, 1, 1);
    tbl[14] = v(0, 0, 8192, 1, 0, 0,   0, 0, 0, 0, 0, 1);  // finished sector, stopped
    tbl[15] = v(0, 0, 8192, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    tbl[16] = v(0, 1, 8192, 0, 1, 0,   1, 0, 1, 0, 1, 0);  // mount + save together -> load
    tbl[17] = v(0, 1, 8192, 0, 1, 0,   1, 0, 1, 0, 1, 0);
    tbl[18] = v(1, 1, 8192, 0, 1, 0,   0, 0, 0, 0, 0, 0);  // reset mid-transfer
    tbl[19] = v(0, 0, 8192, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[20] = v(0, 1, 8192, 1, 0, 0,   0, 0, 0, 0, 0, 0);  // download wins over mount
    tbl[21] = v(0, 0, 8192, 0, 0, 0,   0, 0, 0, 0, 0, 0);

    step(1);
    for (int i = 0; i < 22; i++) begin
      reset = tbl[i].rst; img_mounted = tbl[i].mnt; img_size = tbl[i].sz;
      ioctl_download = tbl[i].dl; save_req = tbl[i].sv; tbl_ack = tbl[i].ack;
      step(1);
      chk($sformatf("vec%0d_flags", i), {27'd0, sd_rd, sd_wr, bk_ena, bk_reset, busy},
          {27'd0, tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_ena, tbl[i].e_bkr, tbl[i].e_bsy});
      chk($sformatf("vec%0d_lba", i), sd_lba, tbl[i].e_lba);
    end

    // Full 16-sector load.
    do_reset();
    ack_en = 1'b1;
    b_rd = rd_cnt; b_wr = wr_cnt; b_bk = bkr_cnt; b_qr = rd_lbas.size();
    img_size = 32'd8192; img_mounted = 1'b1;
    step(1);
    chk("load_busy", 32'(busy), 32'd1);
    wait_idle("load_timeout", 600);
    step(2);
    chk("load_rd_count", 32'(rd_cnt - b_rd), 32'd16);
    bad = 0;
    for (int k = 0; k < 16; k++)
      if (b_qr + k >= rd_lbas.size() || rd_lbas[b_qr + k] != 32'(k)) bad++;
    chk("load_lba_seq", 32'(bad), 32'd0);
    chk("load_bk_reset", 32'(bkr_cnt - b_bk), 32'd1);
    chk("load_wr_count", 32'(wr_cnt - b_wr), 32'd0);
    chk("load_done_flags", {30'd0, busy, bk_ena}, {30'd0, 1'b0, 1'b1});

    // Full 16-sector save.
    img_mounted = 1'b0;
    step(1);
    b_rd = rd_cnt; b_wr = wr_cnt; b_bk = bkr_cnt; b_qw = wr_lbas.size();
    save_req = 1'b1;
    step(1);
    wait_idle("save_timeout", 600);
    step(2);
    save_req = 1'b0;
    chk("save_wr_count", 32'(wr_cnt - b_wr), 32'd16);
    bad = 0;
    for (int k = 0; k < 16; k++)
      if (b_qw + k >= wr_lbas.size() || wr_lbas[b_qw + k] != 32'(k)) bad++;
    chk("save_lba_seq", 32'(bad), 32'd0);
    chk("save_bk_reset", 32'(bkr_cnt - b_bk), 32'd0);
    chk("save_rd_count", 32'(rd_cnt - b_rd), 32'd0);

    // Download during sector 5 of a load.
    b_rd = rd_cnt; b_bk = bkr_cnt;
    img_mounted = 1'b1;
    n = 0;
    while ((rd_cnt - b_rd) < 6 && n < 600) begin step(1); n++; end
    chk("abort_reach_s5", 32'(n < 600), 32'd1);
    ioctl_download = 1'b1;
    step(1);
    wait_idle("abort_timeout", 100);
    step(20);
    chk("abort_rd_count", 32'(rd_cnt - b_rd), 32'd6);
    chk("abort_last_lba", rd_lbas[$], 32'd5);
    chk("abort_bk_ena", 32'(bk_ena), 32'd0);
    chk("abort_bk_reset", 32'(bkr_cnt - b_bk), 32'd0);
    ioctl_download = 1'b0; img_mounted = 1'b0;
    step(2);

    // Reset during sector 3, then a save request with no backup.
    b_rd = rd_cnt;
    img_mounted = 1'b1;
    n = 0;
    while ((rd_cnt - b_rd) < 4 && n < 600) begin step(1); n++; end
    chk("rst_reach_s3", 32'(n < 600), 32'd1);
    reset = 1'b1;
    step(1);
    chk("rst_outputs", {26'd0, sd_rd, sd_wr, bk_ena, bk_reset, busy, 1'b0} | sd_lba, 32'd0);
    reset = 1'b0; img_mounted = 1'b0;
    step(10);
    b_wr = wr_cnt;
    save_req = 1'b1;
    step(5);
    chk("rst_save_ignored", {31'd0, busy}, 32'd0);
    chk("rst_save_wr", 32'(wr_cnt - b_wr), 32'd0);
    save_req = 1'b0;

    // Core write after a load: autosave only when the feature is built in.
    do_reset();
    img_mounted = 1'b1;
    step(1);
    wait_idle("pre_auto_timeout", 600);
    step(5);
    nvram_we = 1'b1;
    step(1);
    nvram_we = 1'b0;
    n = 0;
    while (!sd_wr && n < 300) begin step(1); n++; end
`ifdef SAV_AUTOSAVE_EN
    chk("autosave_delay", 32'(n), 32'd101);
`else
    chk("autosave_off", 32'(n), 32'd300);
`endif
    wait_idle("autosave_timeout", 600);
    step(2);
    b_wr = wr_cnt;
    for (int k = 0; k < 6; k++) begin
      nvram_we = 1'b1;
      step(1);
      nvram_we = 1'b0;
      step(49);
    end
    chk("autosave_quiet_writes", 32'(wr_cnt - b_wr), 32'd0);
    chk("bk_reset_width", 32'(bkr_long), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
